id_decode_pipe: RTL and testbench
=================================

# id_decode_pipe

Pipelined instruction-decode stage for the RISC-V CPU. It replaces the single-cycle combinational decoder with a registered ID/EX boundary. It accepts one instruction per cycle from fetch over a valid/ready handshake and decodes the full control bundle plus a sign-extended immediate of parametrised width. It detects load-use hazards and inserts one-cycle bubbles, honours flush from branch resolution, and counts the bubbles it inserts.

## Interface
- XLEN, 32: datapath and immediate width; legal values 32 or 64.
- HAZARD_EN, 1: 1 enables load-use bubble insertion; 0 passes instructions with no hazard check.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_i  in  32  instruction from fetch.
- in_valid_i  in  1  instr_i valid.
- in_ready_o  out  1  stage accepts instr_i this cycle.
- flush_i  in  1  discard the registered and the incoming instruction.
- out_ready_i  in  1  execute consumes the registered bundle.
- out_valid_o  out  1  registered bundle valid.
- alusrc_o, regwrite_o, branch_o, jump_o, memread_o, memwrite_o, memtoreg_o  out  1 each  registered controls.
- aluop_o  out  2  00 add (load/store/jump/LUI), 01 branch compare, 10 R-type, 11 I-type ALU.
- imm_o  out  XLEN  sign-extended immediate.
- rs1_o, rs2_o, rd_o  out  5 each  register fields.
- funct3_o  out  3  instr[14:12].
- illegal_o  out  1  unsupported opcode.
- bubble_cnt_o  out  16  saturating count of inserted bubbles.

## Operation
- Decode by opcode:
  - R 0110011: regwrite; aluop 10; R-type, no immediate.
  - I-ALU 0010011: alusrc, regwrite; aluop 11; I-immediate.
  - LW 0000011: alusrc, regwrite, memread, memtoreg; aluop 00; I-immediate.
  - SW 0100011: alusrc, memwrite; aluop 00; S-immediate.
  - B 1100011: branch; aluop 01; B-immediate.
  - JAL 1101111: regwrite, jump; aluop 00; J-immediate.
  - JALR 1100111: alusrc, regwrite, jump; aluop 00; I-immediate.
  - LUI 0110111: alusrc, regwrite; aluop 00; U-immediate.
- Any other opcode: all controls 0, illegal_o=1, imm 0. The bundle is still valid and is passed downstream so the trap can be raised.
- Immediates are sign-extended from instr[31] to XLEN. For B and J, bit 0 is 0. For U, instr[31:12]<<12 is then sign-extended.
- Register usage for the hazard check:
  - rs1 is used by R, I-ALU, LW, SW, B, JALR.
  - rs2 is used by R, SW, B.
- Load-use hazard (HAZARD_EN=1), all of the following true:
  - out_valid_o=1 and memread_o=1 and rd_o≠0.
  - in_valid_i=1.
  - The incoming instruction uses rs1 or rs2 equal to rd_o.
- Register update on each edge, priority high to low:
  1. flush_i: out_valid_o←0, controls←0. The incoming instruction is dropped (in_ready_o=1).
  2. out_valid_o=1 and out_ready_i=0: hold all outputs.
  3. Hazard: load a bubble (out_valid_o←0, controls←0) and increment bubble_cnt_o.
  4. in_valid_i=1: load the decoded bundle, out_valid_o←1.
  5. Otherwise: out_valid_o←0.
- in_ready_o = flush_i | (~(out_valid_o & ~out_ready_i) & ~hazard). This is combinational.
- bubble_cnt_o saturates at 0xFFFF. Flush and stall do not count.

## Timing
- Reset: out_valid_o=0. All controls, illegal_o, imm_o, rs1_o, rs2_o, rd_o, funct3_o and bubble_cnt_o are 0.
- Reset mid-operation clears state immediately, with no wait for a clock edge.
- Latency: 1 cycle from acceptance to out_valid_o.
- Throughput: 1 instruction per cycle absent hazard or stall.
- Load-use costs exactly 1 bubble cycle. The dependent instruction is accepted on the following cycle, because the register then holds no load.
- Simultaneous flush and hazard: flush wins and no bubble is counted.
- Simultaneous flush and stall (out_ready_i=0): flush wins.
- in_ready_o must not depend on in_valid_i except through the hazard term.

## Test plan
- Reset, then 0x00500093 (ADDI x1,x0,5) with in_valid_i=1, out_ready_i=1 → next cycle out_valid_o=1, imm_o=5, alusrc_o=1, regwrite_o=1, aluop_o=11, rd_o=1.
- 0x0000A103 (LW x2,0(x1)) then 0x001101B3 (ADD x3,x2,x1) back-to-back → in_ready_o=0 for one cycle, one cycle with out_valid_o=0, ADD appears the cycle after, bubble_cnt_o=1. Repeat with HAZARD_EN=0 → no bubble, bubble_cnt_o=0.
- 0xFE000EE3 (BEQ x0,x0,-4) → branch_o=1, aluop_o=01, imm_o=0xFFFFFFFC. Then 0xFFFFFFFF → illegal_o=1, all controls 0, out_valid_o=1.
- XLEN=64, 0xFFF00093 (ADDI x1,x0,-1) → imm_o=0xFFFFFFFFFFFFFFFF.
- Hold out_ready_i=0 for 3 cycles with a valid bundle → outputs stable, in_ready_o=0. Assert flush_i in cycle 2 → out_valid_o=0 next cycle, in_ready_o=1.
- Assert rst_i asynchronously mid-stream (between edges) → all outputs 0 immediately, bubble_cnt_o=0.

Source files
------------

// File: rtl/id_decode_pipe.sv
// ============================================================================
// Module  : id_decode_pipe
// Purpose : Registered RISC-V ID/EX stage: decode, load-use bubbles, flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decode_pipe #(
    parameter int XLEN      = 32,
    parameter int HAZARD_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            flush_i,
    input  logic            out_ready_i,
    output logic            out_valid_o,
    output logic            alusrc_o,
    output logic            regwrite_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            memread_o,
    output logic            memwrite_o,
    output logic            memtoreg_o,
    output logic [1:0]      aluop_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic            illegal_o,
    output logic [15:0]     bubble_cnt_o
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic [6:0]  opcode;
    logic [4:0]  in_rs1, in_rs2;
    logic        s;
    logic [31:0] imm_i32, imm_s32, imm_b32, imm_j32, imm_u32;

    assign opcode = instr_i[6:0];
    assign in_rs1 = instr_i[19:15];
    assign in_rs2 = instr_i[24:20];
    assign s      = instr_i[31];

    assign imm_i32 = {{20{s}}, instr_i[31:20]};
    assign imm_s32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b32 = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j32 = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_u32 = {instr_i[31:12], 12'b0};

    logic              dec_alusrc, dec_regwrite, dec_branch, dec_jump;
    logic              dec_memread, dec_memwrite, dec_memtoreg, dec_illegal;
    logic [1:0]        dec_aluop;
    logic signed [31:0] dec_imm32;
    logic              use_rs1, use_rs2;

    always_comb begin
        dec_alusrc   = 1'b0;
        dec_regwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_illegal  = 1'b0;
        dec_aluop    = 2'b00;
        dec_imm32    = '0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        case (opcode)
            OP_R: begin
                dec_regwrite = 1'b1; dec_aluop = 2'b10;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IALU: begin
                dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_aluop = 2'b11;
                dec_imm32 = imm_i32; use_rs1 = 1'b1;
            end
            OP_LW: begin
                dec_alusrc = 1'b1; dec_regwrite = 1'b1;
                dec_memread = 1'b1; dec_memtoreg = 1'b1;
                dec_imm32 = imm_i32; use_rs1 = 1'b1;
            end
            OP_SW: begin
                dec_alusrc = 1'b1; dec_memwrite = 1'b1;
                dec_imm32 = imm_s32; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_B: begin
                dec_branch = 1'b1; dec_aluop = 2'b01;
                dec_imm32 = imm_b32; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_JAL: begin
                dec_regwrite = 1'b1; dec_jump = 1'b1; dec_imm32 = imm_j32;
            end
            OP_JALR: begin
                dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_jump = 1'b1;
                dec_imm32 = imm_i32; use_rs1 = 1'b1;
            end
            OP_LUI: begin
                dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_imm32 = imm_u32;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic stall, hazard, load_bundle, bundle_zero;

    // Only a real in-flight load with a non-x0 target can create a hazard
    assign hazard = (HAZARD_EN != 0) && out_valid_o && memread_o && (rd_o != 5'd0)
                    && in_valid_i
                    && ((use_rs1 && (in_rs1 == rd_o)) || (use_rs2 && (in_rs2 == rd_o)));
    assign stall       = out_valid_o & ~out_ready_i;
    assign in_ready_o  = flush_i | (~stall & ~hazard);
    assign load_bundle = flush_i | (~stall & (hazard | in_valid_i));
    assign bundle_zero = flush_i | hazard;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            alusrc_o     <= 1'b0;
            regwrite_o   <= 1'b0;
            branch_o     <= 1'b0;
            jump_o       <= 1'b0;
            memread_o    <= 1'b0;
            memwrite_o   <= 1'b0;
            memtoreg_o   <= 1'b0;
            illegal_o    <= 1'b0;
            aluop_o      <= 2'b00;
            imm_o        <= '0;
            rs1_o        <= '0;
            rs2_o        <= '0;
            rd_o         <= '0;
            funct3_o     <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (flush_i)
                out_valid_o <= 1'b0;
            else if (!stall)
                out_valid_o <= in_valid_i & ~hazard;

            if (load_bundle) begin
                alusrc_o   <= dec_alusrc   & ~bundle_zero;
                regwrite_o <= dec_regwrite & ~bundle_zero;
                branch_o   <= dec_branch   & ~bundle_zero;
                jump_o     <= dec_jump     & ~bundle_zero;
                memread_o  <= dec_memread  & ~bundle_zero;
                memwrite_o <= dec_memwrite & ~bundle_zero;
                memtoreg_o <= dec_memtoreg & ~bundle_zero;
                illegal_o  <= dec_illegal  & ~bundle_zero;
                aluop_o    <= bundle_zero ? 2'b00 : dec_aluop;
                imm_o      <= bundle_zero ? '0 : XLEN'(dec_imm32);
                rs1_o      <= bundle_zero ? 5'd0 : in_rs1;
                rs2_o      <= bundle_zero ? 5'd0 : in_rs2;
                rd_o       <= bundle_zero ? 5'd0 : instr_i[11:7];
                funct3_o   <= bundle_zero ? 3'd0 : instr_i[14:12];
            end

            if (!flush_i && !stall && hazard && (bubble_cnt_o != 16'hFFFF))
                bubble_cnt_o <= bubble_cnt_o + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_decode_pipe.sv
// ============================================================================
// Module  : tb_id_decode_pipe
// Purpose : Directed self-checking bench for id_decode_pipe (32/64-bit, hazard on/off).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid, flush, out_ready;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // Instance a: XLEN=32, hazard detection on
    logic        a_in_ready, a_out_valid, a_alusrc, a_regwrite, a_branch, a_jump;
    logic        a_memread, a_memwrite, a_memtoreg, a_illegal;
    logic [1:0]  a_aluop;
    logic [31:0] a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_funct3;
    logic [15:0] a_bcnt;

    // Instance b: XLEN=32, hazard detection off
    logic        b_in_ready, b_out_valid, b_alusrc, b_regwrite, b_branch, b_jump;
    logic        b_memread, b_memwrite, b_memtoreg, b_illegal;
    logic [1:0]  b_aluop;
    logic [31:0] b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_funct3;
    logic [15:0] b_bcnt;

    // Instance c: XLEN=64, hazard detection on
    logic        c_in_ready, c_out_valid, c_alusrc, c_regwrite, c_branch, c_jump;
    logic        c_memread, c_memwrite, c_memtoreg, c_illegal;
    logic [1:0]  c_aluop;
    logic [63:0] c_imm;
    logic [4:0]  c_rs1, c_rs2, c_rd;
    logic [2:0]  c_funct3;
    logic [15:0] c_bcnt;

    id_decode_pipe #(.XLEN(32), .HAZARD_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(a_in_ready), .flush_i(flush), .out_ready_i(out_ready),
        .out_valid_o(a_out_valid), .alusrc_o(a_alusrc), .regwrite_o(a_regwrite),
        .branch_o(a_branch), .jump_o(a_jump), .memread_o(a_memread),
        .memwrite_o(a_memwrite), .memtoreg_o(a_memtoreg), .aluop_o(a_aluop),
        .imm_o(a_imm), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
        .funct3_o(a_funct3), .illegal_o(a_illegal), .bubble_cnt_o(a_bcnt));

    id_decode_pipe #(.XLEN(32), .HAZARD_EN(0)) dut_nh (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(b_in_ready), .flush_i(flush), .out_ready_i(out_ready),
        .out_valid_o(b_out_valid), .alusrc_o(b_alusrc), .regwrite_o(b_regwrite),
        .branch_o(b_branch), .jump_o(b_jump), .memread_o(b_memread),
        .memwrite_o(b_memwrite), .memtoreg_o(b_memtoreg), .aluop_o(b_aluop),
        .imm_o(b_imm), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
        .funct3_o(b_funct3), .illegal_o(b_illegal), .bubble_cnt_o(b_bcnt));

    id_decode_pipe #(.XLEN(64), .HAZARD_EN(1)) dut64 (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(c_in_ready), .flush_i(flush), .out_ready_i(out_ready),
        .out_valid_o(c_out_valid), .alusrc_o(c_alusrc), .regwrite_o(c_regwrite),
        .branch_o(c_branch), .jump_o(c_jump), .memread_o(c_memread),
        .memwrite_o(c_memwrite), .memtoreg_o(c_memtoreg), .aluop_o(c_aluop),
        .imm_o(c_imm), .rs1_o(c_rs1), .rs2_o(c_rs2), .rd_o(c_rd),
        .funct3_o(c_funct3), .illegal_o(c_illegal), .bubble_cnt_o(c_bcnt));

    // Packed view of the seven single-bit controls plus illegal, MSB first:
    // {alusrc, regwrite, branch, jump, memread, memwrite, memtoreg, illegal}
    logic [7:0] a_ctl;
    assign a_ctl = {a_alusrc, a_regwrite, a_branch, a_jump,
                    a_memread, a_memwrite, a_memtoreg, a_illegal};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", a_out_valid); end
        n_checks++; if (a_ctl !== 8'h00 || a_aluop !== 2'b00) begin n_fail++; $display("FAIL reset_ctl: got ctl=%h aluop=%b expected 00/00", a_ctl, a_aluop); end
        n_checks++; if ({a_imm, a_rs1, a_rs2, a_rd, a_funct3, a_bcnt} !== '0) begin n_fail++; $display("FAIL reset_fields: got imm=%h rd=%0d cnt=%0d expected 0", a_imm, a_rd, a_bcnt); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        instr = 32'h00500093; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready: got %b expected 1", a_in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", a_out_valid); end
        n_checks++; if (a_ctl !== 8'b1100_0000 || a_aluop !== 2'b11) begin n_fail++; $display("FAIL addi_ctl: got ctl=%b aluop=%b expected 11000000/11", a_ctl, a_aluop); end
        n_checks++; if (a_imm !== 32'd5 || a_rd !== 5'd1 || a_rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_fields: got imm=%h rd=%0d rs1=%0d expected 5/1/0", a_imm, a_rd, a_rs1); end
        n_checks++; if (c_imm !== 64'd5) begin n_fail++; $display("FAIL addi_imm64: got %h expected 5", c_imm); end
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_load_use();
        instr = 32'h0000A103; in_valid = 1'b1;       // LW x2,0(x1)
        step();
        n_checks++; if (a_memread !== 1'b1 || a_memtoreg !== 1'b1 || a_rd !== 5'd2 || a_funct3 !== 3'd2) begin n_fail++; $display("FAIL lw_decode: got memread=%b memtoreg=%b rd=%0d f3=%0d expected 1/1/2/2", a_memread, a_memtoreg, a_rd, a_funct3); end
        instr = 32'h001101B3;                        // ADD x3,x2,x1
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_in_ready: got %b expected 0", a_in_ready); end
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL nohaz_in_ready: got %b expected 1", b_in_ready); end
        step();
        n_checks++; if (a_out_valid !== 1'b0 || a_ctl !== 8'h00) begin n_fail++; $display("FAIL bubble: got valid=%b ctl=%h expected 0/00", a_out_valid, a_ctl); end
        n_checks++; if (a_bcnt !== 16'd1) begin n_fail++; $display("FAIL bubble_cnt: got %0d expected 1", a_bcnt); end
        n_checks++; if (b_out_valid !== 1'b1 || b_rd !== 5'd3 || b_aluop !== 2'b10 || b_bcnt !== 16'd0) begin n_fail++; $display("FAIL nohaz_pass: got valid=%b rd=%0d aluop=%b cnt=%0d expected 1/3/10/0", b_out_valid, b_rd, b_aluop, b_bcnt); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL after_bubble_ready: got %b expected 1", a_in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1 || a_rd !== 5'd3 || a_rs1 !== 5'd2 || a_rs2 !== 5'd1 || a_ctl !== 8'b0100_0000 || a_aluop !== 2'b10) begin n_fail++; $display("FAIL add_after_bubble: got valid=%b rd=%0d ctl=%b aluop=%b expected 1/3/01000000/10", a_out_valid, a_rd, a_ctl, a_aluop); end
        n_checks++; if (a_bcnt !== 16'd1 || c_bcnt !== 16'd1) begin n_fail++; $display("FAIL cnt_stable: got a=%0d c=%0d expected 1/1", a_bcnt, c_bcnt); end
    endtask

    task automatic test_back_to_back();
        instr = 32'hFE000EE3; in_valid = 1'b1;       // BEQ x0,x0,-4
        step();
        instr = 32'hFFFFFFFF;
        n_checks++; if (a_out_valid !== 1'b1 || a_ctl !== 8'b0010_0000 || a_aluop !== 2'b01) begin n_fail++; $display("FAIL beq_ctl: got valid=%b ctl=%b aluop=%b expected 1/00100000/01", a_out_valid, a_ctl, a_aluop); end
        n_checks++; if (a_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_imm: got %h expected fffffffc", a_imm); end
        n_checks++; if (c_imm !== 64'hFFFFFFFFFFFFFFFC) begin n_fail++; $display("FAIL beq_imm64: got %h expected fffffffffffffffc", c_imm); end
        step();
        in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1 || a_ctl !== 8'b0000_0001 || a_aluop !== 2'b00 || a_imm !== 32'd0) begin n_fail++; $display("FAIL illegal: got valid=%b ctl=%b aluop=%b imm=%h expected 1/00000001/00/0", a_out_valid, a_ctl, a_aluop, a_imm); end
        step();
    endtask

    task automatic test_imm64();
        instr = 32'hFFF00093; in_valid = 1'b1;       // ADDI x1,x0,-1
        step();
        in_valid = 1'b0;
        n_checks++; if (c_imm !== 64'hFFFFFFFFFFFFFFFF || c_out_valid !== 1'b1) begin n_fail++; $display("FAIL imm64_neg: got imm=%h valid=%b expected ffffffffffffffff/1", c_imm, c_out_valid); end
        n_checks++; if (a_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL imm32_neg: got %h expected ffffffff", a_imm); end
        step();
    endtask

    task automatic test_stall_flush();
        instr = 32'h00500093; in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0; instr = 32'h00700113;      // ADDI x2,x0,7 waits
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", a_in_ready); end
        step();
        n_checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'd5 || a_rd !== 5'd1) begin n_fail++; $display("FAIL stall_hold1: got valid=%b imm=%h rd=%0d expected 1/5/1", a_out_valid, a_imm, a_rd); end
        step();
        n_checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'd5 || a_rd !== 5'd1 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold2: got valid=%b imm=%h rd=%0d rdy=%b expected 1/5/1/0", a_out_valid, a_imm, a_rd, a_in_ready); end
        flush = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", a_in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_regwrite !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_result: got valid=%b regwrite=%b rdy=%b expected 0/0/1", a_out_valid, a_regwrite, a_in_ready); end
        out_ready = 1'b1;
        // Flush coinciding with a load-use hazard: flush wins, no bubble counted
        instr = 32'h0000A103; in_valid = 1'b1;
        step();
        instr = 32'h001101B3; flush = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_haz_ready: got %b expected 1", a_in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b0 || a_bcnt !== 16'd1) begin n_fail++; $display("FAIL flush_haz: got valid=%b cnt=%0d expected 0/1", a_out_valid, a_bcnt); end
    endtask

    task automatic test_async_reset();
        instr = 32'h0000A103; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2;                                           // mid-cycle, away from any edge
        rst = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_ctl !== 8'h00 || a_imm !== 32'd0 || a_rd !== 5'd0 || a_bcnt !== 16'd0) begin n_fail++; $display("FAIL async_reset: got valid=%b ctl=%h imm=%h rd=%0d cnt=%0d expected all 0", a_out_valid, a_ctl, a_imm, a_rd, a_bcnt); end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_back_to_back();
        test_imm64();
        test_stall_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
